// File: rtl/keypad_pkg.sv
// Shared types and constants for the calculator front-panel keypad.
package keypad_pkg;

    localparam int KEYPAD_ROWS = 7;
    localparam int KEYPAD_COLS = 5;
    localparam int KEY_CODE_W  = $clog2(KEYPAD_ROWS * KEYPAD_COLS);

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } scan_res_e;

    // Calculator legend, code = row*KEYPAD_COLS + col
    localparam logic [KEY_CODE_W-1:0] KEY_CLEAR  = 6'd0;
    localparam logic [KEY_CODE_W-1:0] KEY_DIGIT0 = 6'd30;
    localparam logic [KEY_CODE_W-1:0] KEY_POINT  = 6'd31;
    localparam logic [KEY_CODE_W-1:0] KEY_PLUS   = 6'd33;
    localparam logic [KEY_CODE_W-1:0] KEY_EQUALS = 6'd34;

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Parameterized-width two-flop synchronizer; idles high to match pulled-up lines.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row drive, full-scan debounce, valid/ready key delivery.
// Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS           = KEYPAD_ROWS,
    parameter int COLS           = KEYPAD_COLS,
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 70,
    parameter int REPEAT_RATE    = 14
) (
    input  logic                           clock,
    input  logic                           reset,
    output logic [ROWS-1:0]                row_n,
    input  logic [COLS-1:0]                col_n,
    output logic [$clog2(ROWS*COLS)-1:0]   key_code,
    output logic                           key_valid,
    input  logic                           key_ready,
    output logic                           key_held,
    output logic                           overrun
);

    localparam int CW = $clog2(ROWS * COLS);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS) + 1;

    logic [COLS-1:0] col_s;
    logic [DW-1:0]   dwell;
    logic [RW-1:0]   row_idx;
    logic            last_dwell;
    logic            scan_done;

    logic [1:0]      acc_cnt,  acc_cnt_n;
    logic [CW-1:0]   acc_code, acc_code_n;

    scan_res_e       res_kind, prev_kind, acpt_kind;
    logic [CW-1:0]   res_code, prev_code, acpt_code;
    logic [SW-1:0]   stable_cnt, stable_n;
    logic            accept;
    logic            emit;
    logic [CW-1:0]   emit_code;

    sync2 #(.W(COLS)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (col_n),
        .q     (col_s)
    );

    assign last_dwell = (dwell == DW'(SCAN_DIV - 1));

    always_comb begin
        row_n          = '1;
        row_n[row_idx] = 1'b0;
    end

    // Accumulator clears on the evaluation cycle; row 0 is not sampled until SCAN_DIV cycles later.
    always_comb begin
        acc_cnt_n  = acc_cnt;
        acc_code_n = acc_code;
        if (scan_done) begin
            acc_cnt_n  = '0;
            acc_code_n = '0;
        end
        if (last_dwell) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (!col_s[c]) begin
                    if (acc_cnt_n == 2'd0)
                        acc_code_n = CW'(row_idx * COLS + c);
                    if (acc_cnt_n != 2'd2)
                        acc_cnt_n = acc_cnt_n + 2'd1;
                end
            end
        end
    end

    always_comb begin
        res_kind = RES_NONE;
        res_code = '0;
        if (acc_cnt == 2'd1) begin
            res_kind = RES_KEY;
            res_code = acc_code;
        end else if (acc_cnt == 2'd2) begin
            res_kind = RES_MULTI;
        end

        stable_n = '0;
        if (res_kind == prev_kind && res_code == prev_code)
            stable_n = (stable_cnt == SW'(DEBOUNCE_SCANS - 1)) ? stable_cnt : stable_cnt + 1'b1;

        accept = scan_done && (stable_n == SW'(DEBOUNCE_SCANS - 1))
                 && !(res_kind == acpt_kind && res_code == acpt_code);
    end

`ifdef KEYPAD_REPEAT_EN
    logic [15:0] rep_cnt;
    logic        rep_armed;
    logic        rep_fire;

    always_comb begin
        rep_fire  = scan_done && !accept && (acpt_kind == RES_KEY)
                    && ((rep_cnt + 16'd1) == (rep_armed ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY)));
        emit      = (accept && res_kind == RES_KEY) || rep_fire;
        emit_code = accept ? res_code : acpt_code;
    end

    always_ff @(posedge clock) begin
        if (reset || accept) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (scan_done && acpt_kind == RES_KEY) begin
            if (rep_fire) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b1;
            end else begin
                rep_cnt   <= rep_cnt + 16'd1;
            end
        end
    end
`else
    // Repeat timing has no meaning without the repeat counter.
    localparam int repeat_cfg_unused = REPEAT_DELAY + REPEAT_RATE;

    always_comb begin
        emit      = accept && (res_kind == RES_KEY);
        emit_code = res_code;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            dwell      <= '0;
            row_idx    <= '0;
            scan_done  <= 1'b0;
            acc_cnt    <= '0;
            acc_code   <= '0;
            prev_kind  <= RES_NONE;
            prev_code  <= '0;
            acpt_kind  <= RES_NONE;
            acpt_code  <= '0;
            stable_cnt <= '0;
            key_code   <= '0;
            key_valid  <= 1'b0;
            key_held   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            scan_done <= last_dwell && (row_idx == RW'(ROWS - 1));
            if (last_dwell) begin
                dwell   <= '0;
                row_idx <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
            end else begin
                dwell   <= dwell + 1'b1;
            end

            acc_cnt  <= acc_cnt_n;
            acc_code <= acc_code_n;

            if (scan_done) begin
                prev_kind  <= res_kind;
                prev_code  <= res_code;
                stable_cnt <= stable_n;
            end

            if (accept) begin
                acpt_kind <= res_kind;
                acpt_code <= res_code;
                key_held  <= (res_kind == RES_KEY);
            end

            if (emit) begin
                if (!key_valid || key_ready) begin
                    key_code  <= emit_code;
                    key_valid <= 1'b1;
                end else begin
                    overrun   <= 1'b1;
                end
            end else if (key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner (SCAN_DIV=8, DEBOUNCE_SCANS=2).
module tb_keypad_scanner;

    logic       clock;
    logic       reset;
    logic [6:0] row_n;
    logic [4:0] col_n;
    logic [5:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic       overrun;

    logic [34:0] pressed;
    int          n_checks;
    int          n_fail;
    int          xfer_cnt;
    logic [5:0]  last_code;
    int          xfer_base;
    int          exp_rep;
    logic        found;

    keypad_scanner #(
        .ROWS           (7),
        .COLS           (5),
        .SCAN_DIV       (8),
        .DEBOUNCE_SCANS (2),
        .REPEAT_DELAY   (3),
        .REPEAT_RATE    (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Keypad matrix: a pressed key shorts its column to the driven row.
    always_comb begin
        col_n = '1;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 5; c++)
                if (!row_n[r] && pressed[r*5+c])
                    col_n[c] = 1'b0;
    end

    always @(posedge clock) begin
        if (!reset && key_valid && key_ready) begin
            xfer_cnt  <= xfer_cnt + 1;
            last_code <= key_code;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        xfer_cnt  = 0;
        last_code = '0;
        pressed   = '0;
        key_ready = 1'b1;
        reset     = 1'b1;
        cycles(3);
        reset = 1'b0;

        check("rst_row_n", 32'(row_n), 32'h7E);
        check("rst_code", 32'(key_code), 0);
        check("rst_valid", 32'(key_valid), 0);
        check("rst_held", 32'(key_held), 0);
        check("rst_overrun", 32'(overrun), 0);

        // Idle scan: each row held for 8 cycles, no key reported.
        for (int i = 0; i < 56; i++) begin
            check("idle_row_n", 32'(row_n), 32'(~(7'd1 << (i / 8)) & 7'h7F));
            check("idle_valid", 32'(key_valid), 0);
            cycles(1);
        end
        check("wrap_row_n", 32'(row_n), 32'h7E);

        // Code 13 pressed at a scan boundary: valid 113 cycles later, one transfer.
        pressed[13] = 1'b1;
        cycles(112);
        check("press_early_valid", 32'(key_valid), 0);
        cycles(1);
        check("press_valid", 32'(key_valid), 1);
        check("press_code", 32'(key_code), 13);
        check("press_held", 32'(key_held), 1);
        cycles(1);
        check("press_xfer_clear", 32'(key_valid), 0);
        check("press_xfer_cnt", 32'(xfer_cnt), 1);
        pressed = '0;
        cycles(56);
        check("release_one_scan_held", 32'(key_held), 1);
        cycles(112);
        check("release_held", 32'(key_held), 0);
        check("release_no_emit", 32'(xfer_cnt), 1);

        // Consumer stalled: second key is dropped and flagged.
        key_ready = 1'b0;
        pressed[13] = 1'b1;
        cycles(168);
        check("stall_valid", 32'(key_valid), 1);
        check("stall_code", 32'(key_code), 13);
        check("stall_held", 32'(key_held), 1);
        check("stall_overrun0", 32'(overrun), 0);
        pressed = '0;
        cycles(168);
        check("stall_rel_held", 32'(key_held), 0);
        check("stall_rel_overrun", 32'(overrun), 0);
        pressed[34] = 1'b1;
        cycles(168);
        check("ovr_held", 32'(key_held), 1);
        check("ovr_overrun", 32'(overrun), 1);
        check("ovr_code", 32'(key_code), 13);
        check("ovr_valid", 32'(key_valid), 1);
        key_ready = 1'b1;
        cycles(1);
        check("ovr_drain_valid", 32'(key_valid), 0);
        check("ovr_drain_cnt", 32'(xfer_cnt), 2);
        check("ovr_drain_code", 32'(last_code), 13);
        pressed = '0;
        cycles(168);
        check("ovr_rel_held", 32'(key_held), 0);

        // Two keys at once never emit.
        pressed[0] = 1'b1;
        pressed[7] = 1'b1;
        cycles(168);
        check("multi_held", 32'(key_held), 0);
        check("multi_valid", 32'(key_valid), 0);
        check("multi_cnt", 32'(xfer_cnt), 2);
        pressed = '0;
        cycles(168);

        // Key visible for a single scan only.
        pressed[5] = 1'b1;
        cycles(56);
        pressed = '0;
        cycles(168);
        check("glitch_cnt", 32'(xfer_cnt), 2);
        check("glitch_valid", 32'(key_valid), 0);
        check("glitch_held", 32'(key_held), 0);
        check("pre_reset_overrun", 32'(overrun), 1);

        // Reset in the middle of row 4's dwell.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (row_n == 7'h6F) found = 1'b1;
            else cycles(1);
        end
        check("row4_found", 32'(found), 1);
        cycles(3);
        reset = 1'b1;
        cycles(1);
        check("mid_rst_row_n", 32'(row_n), 32'h7E);
        check("mid_rst_code", 32'(key_code), 0);
        check("mid_rst_valid", 32'(key_valid), 0);
        check("mid_rst_held", 32'(key_held), 0);
        check("mid_rst_overrun", 32'(overrun), 0);
        cycles(2);

        // Code 20 held for 11 scans starting at the scan boundary.
        xfer_base = xfer_cnt;
        reset = 1'b0;
        pressed[20] = 1'b1;
        cycles(11 * 56);
        pressed = '0;
        cycles(168);
`ifdef KEYPAD_REPEAT_EN
        exp_rep = 5;
`else
        exp_rep = 1;
`endif
        check("repeat_cnt", 32'(xfer_cnt - xfer_base), 32'(exp_rep));
        check("repeat_code", 32'(last_code), 20);
        check("repeat_held", 32'(key_held), 0);
        check("repeat_overrun", 32'(overrun), 0);

        cycles(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad scanner for the calculator front panel. It drives the 7 keypad row lines one at a time, samples the 5 column lines, and debounces the result over whole scans. Each accepted keypress is delivered as a key code over a valid/ready handshake to the calculator controller. It is the driving end of the ROW/COL keypad interface that the board top level currently only samples.

## Interface
Parameters:
- ROWS, 7: number of row lines driven.
- COLS, 5: number of column lines sampled.
- SCAN_DIV, 50000: clock cycles each row is driven (dwell); minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results required to accept a change; minimum 1.
- REPEAT_DELAY, 70: scans a key must be held before the first auto-repeat.
- REPEAT_RATE, 14: scans between subsequent auto-repeats.

Ports (one clock; reset is synchronous and active-high):
- clock, in, 1: system clock, 50 MHz.
- reset, in, 1: synchronous, active-high.
- row_n, out, ROWS: row drive, active-low, exactly one bit low.
- col_n, in, COLS: column sense, active-low, externally pulled up, asynchronous.
- key_code, out, $clog2(ROWS*COLS): equals row*COLS + col; range 0..34.
- key_valid, out, 1: key_code holds an undelivered code.
- key_ready, in, 1: consumer accepts the code.
- key_held, out, 1: the accepted state is a single key currently pressed.
- overrun, out, 1: sticky; a code was dropped because key_valid was still pending.

## Operation
- col_n passes through a 2-flop synchronizer before any use.
- Row sequencer:
  - Dwell counter runs 0..SCAN_DIV-1 on the current row, then advances to the next row.
  - Row index wraps from ROWS-1 to 0.
  - Synchronized columns are sampled on the last dwell cycle of each row.
- Scan accumulator, per full scan rows 0..ROWS-1:
  - Counts pressed positions, saturating at 2, and records the code of the first one.
  - Scan result R is NONE (0 pressed), KEY(c) (exactly 1), or MULTI (2 or more).
  - R is evaluated on the cycle after the row ROWS-1 sample.
- Debounce:
  - If R equals the previous R, stable_cnt increments, saturating.
  - Otherwise stable_cnt clears and the previous R is replaced by R.
  - When stable_cnt reaches DEBOUNCE_SCANS-1, R becomes the accepted state.
- Acceptance transitions:
  - Accepted state becomes KEY(c) from any other state: emit c and set key_held.
  - Accepted state becomes NONE or MULTI: clear key_held, no emission.
  - Accepted state already equals R: no action.
  - MULTI never emits.
- Emission and handshake:
  - If key_valid is low, or a transfer (key_valid && key_ready) occurs in the same cycle, load key_code and set key_valid.
  - Otherwise drop the new code and set overrun.
  - On a transfer with no new emission, key_valid clears on the next cycle.
  - key_code is stable while key_valid is high.
- Reset mid-scan: all state returns to reset values; scanning restarts at row 0 and the debounce history is discarded.

## Timing
- Reset values:
  - row_n = all ones except bit 0 low (row 0 driven).
  - key_code = 0, key_valid = 0, key_held = 0, overrun = 0.
  - Dwell counter, row index, and stable_cnt = 0; previous R and accepted state = NONE.
- Row 0 dwell counting begins on the first cycle after reset deasserts.
- Full scan period = ROWS*SCAN_DIV cycles.
- Synchronizer latency is 2 cycles. Sampling on the last dwell cycle gives at least SCAN_DIV-2 cycles of settling.
- Press-to-valid latency: key_valid rises 2 cycles after the final row sample of the DEBOUNCE_SCANS-th consecutive scan containing the key (1 cycle for evaluation, 1 registered).
- Release is recognized after DEBOUNCE_SCANS scans with result NONE.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - While the accepted state stays KEY(c), a scan counter re-emits c after REPEAT_DELAY scans, then every REPEAT_RATE scans.
  - Re-emissions follow the same overrun rule.
  - The counter clears on any accepted-state change.
- KEYPAD_REPEAT_EN undefined: exactly one emission per accepted press. REPEAT_DELAY and REPEAT_RATE are ignored and no repeat logic is synthesized.

## Structure
- Shared package keypad_pkg holds:
  - The scan-result enum (NONE, KEY, MULTI).
  - Constants KEYPAD_ROWS = 7, KEYPAD_COLS = 5, and KEY_CODE_W.
  - Key-code constants for the calculator legend, e.g. KEY_CLEAR and KEY_EQUALS.
- One sub-module, sync2: a parameterized-width 2-flop synchronizer for col_n.
- The row sequencer, accumulator, debounce, and output register stay in keypad_scanner.

## Test plan
Bench parameters: SCAN_DIV=8, DEBOUNCE_SCANS=2, REPEAT_DELAY=3, REPEAT_RATE=2. Scan period is 56 cycles.
- Reset then idle, col_n all ones: row_n cycles 7E,7D,7B,77,6F,5F,3F, 8 cycles each; key_valid never rises.
- Row 2, col 3 held pressed (col_n bit 3 low while row_n bit 2 low), key_ready=1:
  - key_valid pulses once with key_code=13 about 2 scans after press; key_held=1.
  - On release, key_held=0 after 2 NONE scans.
- Same press with key_ready=0: key_valid stays high with code 13. A second key (row 6 col 4, code 34) is accepted after release, so overrun=1 and key_code remains 13.
- Two keys (codes 0 and 7) pressed together: result MULTI, no emission, key_held=0.
- Single-scan glitch on code 5: no emission.
- Reset asserted mid-dwell on row 4: next cycle row_n=7E and all outputs at reset values.
- With KEYPAD_REPEAT_EN and code 20 held, key_ready=1: emission at acceptance, then after 3 scans, then every 2 scans; without the macro, one emission only.
